// File: rtl/aes256_key_expand_if.sv
// Round-key streaming interface for aes256_key_expand: start/key request,
// valid/ready round-key stream and the key-store read port.
interface aes256_key_expand_if;
  logic         start;
  logic [255:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_num;
  logic         done;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;

  modport master (
    output start, key_in, rk_ready, rd_idx,
    input  busy, rk_valid, rk_data, rk_num, done, rd_key
  );

  modport slave (
    input  start, key_in, rk_ready, rd_idx,
    output busy, rk_valid, rk_data, rk_num, done, rd_key
  );
endinterface

// File: rtl/aes256_key_expand.sv
// Iterative AES-256 key schedule: streams rk0..rk14 from a sliding 256-bit window.
// Optional round-key register file enabled by AES_KEY_STORE_EN.
module aes256_key_expand (
  input logic                  clk,
  input logic                  rst,
  aes256_key_expand_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;

  state_t       state, state_nx;
  logic [127:0] win_a, win_b, win_a_nx, win_b_nx;
  logic [3:0]   num, num_nx;
  logic         xfer;
  logic [4:0]   j;
  logic [31:0]  t_src, t_sub, t;
  logic [7:0]   rcon;
  logic [31:0]  n0, n1, n2, n3;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as x^254 (x^2 * x^4 * ... * x^128); maps 0 to 0 as AES requires.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, r;
    sq = x;
    r  = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
             ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  assign xfer  = (state == STREAM) && bus.rk_ready;
  assign j     = {1'b0, num} + 5'd2;
  assign t_src = j[0] ? win_b[31:0] : {win_b[23:0], win_b[31:24]};
  assign t_sub = {sbox(t_src[31:24]), sbox(t_src[23:16]),
                  sbox(t_src[15:8]),  sbox(t_src[7:0])};

  always_comb begin
    rcon = 8'h00;
    case (j[4:1])
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      default: rcon = 8'h00;
    endcase
  end

  assign t  = j[0] ? t_sub : (t_sub ^ {rcon, 24'h000000});
  assign n0 = win_a[127:96] ^ t;
  assign n1 = win_a[95:64]  ^ n0;
  assign n2 = win_a[63:32]  ^ n1;
  assign n3 = win_a[31:0]   ^ n2;

  always_comb begin
    state_nx = state;
    win_a_nx = win_a;
    win_b_nx = win_b;
    num_nx   = num;
    case (state)
      IDLE, FINISH: begin
        state_nx = IDLE;
        if (bus.start) begin
          win_a_nx = bus.key_in[255:128];
          win_b_nx = bus.key_in[127:0];
          num_nx   = '0;
          state_nx = STREAM;
        end
      end
      STREAM: begin
        if (bus.rk_ready) begin
          win_a_nx = win_b;
          win_b_nx = {n0, n1, n2, n3};
          if (num == 4'd14) begin
            state_nx = FINISH;
          end else begin
            num_nx = num + 4'd1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      win_a <= '0;
      win_b <= '0;
      num   <= '0;
    end else begin
      state <= state_nx;
      win_a <= win_a_nx;
      win_b <= win_b_nx;
      num   <= num_nx;
    end
  end

  assign bus.busy     = (state == STREAM);
  assign bus.rk_valid = (state == STREAM);
  assign bus.done     = (state == FINISH);
  assign bus.rk_data  = win_a;
  assign bus.rk_num   = num;

`ifdef AES_KEY_STORE_EN
  logic [127:0] store [15];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 15; i++) store[i] <= '0;
    end else if (xfer) begin
      store[num] <= win_a;
    end
  end

  assign bus.rd_key = (bus.rd_idx <= 4'd14) ? store[bus.rd_idx] : '0;
`else
  logic unused_rd;
  assign unused_rd  = ^{bus.rd_idx, xfer};
  assign bus.rd_key = '0;
`endif

endmodule

// File: doc/aes256_key_expand.md
# aes256_key_expand

Iterative AES-256 key-schedule engine that sits directly upstream of the `Encrypt` datapath. It accepts a 256-bit cipher key and streams the 15 round keys, rk0..rk14, over a valid/ready handshake, at one round key per cycle when the consumer is ready. Each round key is derived from the previous two, so the engine needs only one 4-byte SubWord per cycle.

## Interface
- No parameters; the block is fixed to AES-256 (Nk=8, Nr=14).
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: request expansion of `key_in`; sampled only while `busy`=0.
- `key_in` input 256: cipher key; bits [255:248] are key byte 0.
- `busy` output 1: high from the cycle after start is accepted until expansion ends.
- `rk_valid` output 1: `rk_data` and `rk_num` are valid.
- `rk_ready` input 1: consumer accepts the current round key.
- `rk_data` output 128: round key; bits [127:96] are its first word w[4k].
- `rk_num` output 4: round index k, 0..14.
- `done` output 1: one-cycle pulse after rk14 is transferred.
- `rd_idx` input 4: key-store read index; used only with `AES_KEY_STORE_EN`.
- `rd_key` output 128: key-store read data.

## Operation
- State machine: IDLE, STREAM, FINISH.
- IDLE:
  - `start`=1 latches `key_in` into a 256-bit window {A,B}, with A=key[255:128] and B=key[127:0].
  - Sets `rk_num`=0 and goes to STREAM.
- STREAM:
  - `rk_data` always equals A.
  - A transfer occurs on any cycle with `rk_valid`&`rk_ready`.
  - On a transfer: A<=B, B<=next(A,B), `rk_num`++.
  - When the transfer is of rk14, go to FINISH.
- next(A,B) for the new key index j=k+2:
  - t = B word 3.
  - If j is even: t = SubWord(RotWord(t)) ^ {Rcon[j/2],24'h0}.
  - If j is odd: t = SubWord(t).
  - n0 = A0^t, n1 = A1^n0, n2 = A2^n1, n3 = A3^n2.
- Rcon[1..7] = 01,02,04,08,10,20,40.
- S-box: GF(2^8) inverse followed by the affine transform, computed in-block with 4 instances.
- Computing next() for j>14 is harmless; those results are never emitted.
- FINISH: `done`=1 and `busy`=0 for one cycle, then return to IDLE.
- `start` while `busy`=1 is ignored and does not corrupt the stream.
- `key_in` may change freely after the start cycle.

## Timing
- Reset values: `busy`=0, `rk_valid`=0, `rk_data`=0, `rk_num`=0, `done`=0, internal window=0, state=IDLE.
- `rd_key`=0 after reset when `AES_KEY_STORE_EN` is defined.
- Start accepted at cycle N:
  - N+1: `rk_valid`=1, `busy`=1, `rk_num`=0.
  - With `rk_ready` held at 1, rk k is presented at cycle N+1+k.
  - rk14 is presented at N+15.
  - `done` pulses at N+16, with `rk_valid`=0 and `busy`=0 in the same cycle.
- Back-pressure: while `rk_ready`=0, `rk_valid`, `rk_data` and `rk_num` hold stable.
- Next-start: the earliest new start is sampled at N+16 (state is FINISH, `busy`=0); it takes effect as for IDLE.
- Asynchronous reset mid-stream immediately clears all state and outputs to reset values; no partial `done` is produced.
- No combinational path from `rk_ready` to `rk_data`.

## Configuration
- `AES_KEY_STORE_EN` defined:
  - Instantiate a 15x128 register file written with each round key on its transfer.
  - `rd_key` = store[`rd_idx`], a combinational read; entries persist until overwritten.
  - `rd_idx`>14 returns 0.
  - The store is cleared by reset.
- `AES_KEY_STORE_EN` undefined:
  - No store is built.
  - `rd_key` is tied to 0 and `rd_idx` is ignored.

## Test plan
- Stream, `rk_ready`=1, key 000102…1e1f (FIPS-197 C.3):
  - rk0=000102030405060708090a0b0c0d0e0f, rk1=101112131415161718191a1b1c1d1e1f.
  - rk2=a573c29fa176c498a97fce93a572c09c, rk3=1651a8cd0244beda1a5da4c10640bade.
  - rk14=24fc79ccbf0979e9371ac23c6d68de36.
  - `done` at start+16.
- Back-pressure, same key, `rk_ready` toggled pseudo-randomly:
  - Identical 15-key sequence.
  - Outputs are stable throughout every stall cycle.
  - `done` follows the rk14 transfer by exactly 1 cycle.
- Start while busy: assert `start` with key all-FF at rk5.
  - Stream continues with the C.3 keys unaffected.
  - A start at the `done` cycle then yields rk0 = ffff…ff.
- Reset mid-stream: drop `rst` at rk7.
  - All outputs 0 asynchronously.
  - After release, a new start with the C.3 key produces rk0 again.
- All-zero key:
  - rk2=62636363626363636263636362636363.
  - rk14 matches the software model.
- With `AES_KEY_STORE_EN`, after a complete C.3 stream:
  - `rd_idx`=2 reads a573c29f…c09c.
  - `rd_idx`=15 reads 0.
